// File: rtl/fp_add_operand_sequencer_if.sv
// rtl/fp_add_operand_sequencer_if.sv - operand stream, adder bus and result stream of the fp add sequencer
interface fp_add_operand_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sub;

    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_bit;
    logic [31:0] add_result;
    logic        add_ovf;
    logic        add_unf;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_unf;

    modport master (
        output in_valid, in_data, in_sub, out_ready, add_result, add_ovf, add_unf,
        input  in_ready, add_a, add_b, add_bit, out_valid, out_data, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_data, in_sub, out_ready, add_result, add_ovf, add_unf,
        output in_ready, add_a, add_b, add_bit, out_valid, out_data, out_ovf, out_unf
    );
endinterface

// File: rtl/fp_add_operand_sequencer.sv
// rtl/fp_add_operand_sequencer.sv - collects A/B operands, drives a combinational fp adder, registers the sum
module fp_add_operand_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    fp_add_operand_sequencer_if.slave bus,
    input  logic                      clr_sticky_i,
    output logic                      sticky_ovf_o,
    output logic                      sticky_unf_o,
    output logic [CNT_W-1:0]          op_count_o
);

    // Settle counter only needs to hold SETTLE_CYCLES-1.
    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_B,
        ST_SETTLE,
        ST_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [SC_W-1:0]   cnt_q, cnt_d;
    logic [31:0]       add_a_q, add_a_d;
    logic [31:0]       add_b_q, add_b_d;
    logic              add_bit_q, add_bit_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_unf_q, out_unf_d;
    logic              out_valid_q, out_valid_d;
    logic              sticky_ovf_q, sticky_ovf_d;
    logic              sticky_unf_q, sticky_unf_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;
    logic              in_ready_c;
    logic              deliver_c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_bit_q    <= 1'b0;
            out_data_q   <= '0;
            out_ovf_q    <= 1'b0;
            out_unf_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_bit_q    <= add_bit_d;
            out_data_q   <= out_data_d;
            out_ovf_q    <= out_ovf_d;
            out_unf_q    <= out_unf_d;
            out_valid_q  <= out_valid_d;
            sticky_ovf_q <= sticky_ovf_d;
            sticky_unf_q <= sticky_unf_d;
            op_count_q   <= op_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_bit_d    = add_bit_q;
        out_data_d   = out_data_q;
        out_ovf_d    = out_ovf_q;
        out_unf_d    = out_unf_q;
        out_valid_d  = out_valid_q;
        in_ready_c   = 1'b0;
        deliver_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    add_a_d = bus.in_data;
                    state_d = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    // Subtraction is folded into B's sign so the adder only ever adds.
                    add_b_d   = {bus.in_data[31] ^ bus.in_sub, bus.in_data[30:0]};
                    add_bit_d = (add_a_q[30:23] != 8'd0) && (bus.in_data[30:23] != 8'd0);
                    cnt_d     = SC_LOAD;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    out_data_d  = bus.add_result;
                    out_ovf_d   = bus.add_ovf;
                    out_unf_d   = bus.add_unf;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    deliver_c   = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A clear in the same cycle as a delivery wins over the delivered flags.
        sticky_ovf_d = sticky_ovf_q;
        sticky_unf_d = sticky_unf_q;
        if (clr_sticky_i) begin
            sticky_ovf_d = 1'b0;
            sticky_unf_d = 1'b0;
        end else if (deliver_c) begin
            sticky_ovf_d = sticky_ovf_q | out_ovf_q;
            sticky_unf_d = sticky_unf_q | out_unf_q;
        end

        op_count_d = deliver_c ? (op_count_q + 1'b1) : op_count_q;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_bit   = add_bit_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_unf   = out_unf_q;
    assign sticky_ovf_o  = sticky_ovf_q;
    assign sticky_unf_o  = sticky_unf_q;
    assign op_count_o    = op_count_q;

endmodule

// File: tb/tb_fp_add_operand_sequencer.sv
// tb/tb_fp_add_operand_sequencer.sv - randomized self-checking bench, two instances (settle 1 / settle 4)
module tb_fp_add_operand_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    fp_add_operand_sequencer_if bus0 ();
    fp_add_operand_sequencer_if bus1 ();

    logic        in_valid[2];
    logic [31:0] in_data[2];
    logic        in_sub[2];
    logic        out_ready[2];
    logic        clr[2];

    logic        o_in_ready[2];
    logic [31:0] o_add_a[2];
    logic [31:0] o_add_b[2];
    logic        o_add_bit[2];
    logic        o_out_valid[2];
    logic [31:0] o_out_data[2];
    logic        o_out_ovf[2];
    logic        o_out_unf[2];
    logic        o_sticky_ovf[2];
    logic        o_sticky_unf[2];
    logic [15:0] o_op_count[2];
    logic [1:0]  op_count1;

    // Model state: delivered count and sticky flags per instance.
    int          m_cnt[2];
    logic        m_sovf[2];
    logic        m_sunf[2];

    function automatic real f2r(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    // Stand-in for the external adder: {ovf, unf, result}, truncating, denormals flushed.
    function automatic logic [33:0] fadd(input logic [31:0] a, input logic [31:0] b);
        real         r;
        logic [63:0] d;
        int          e;
        r = f2r(a) + f2r(b);
        if (r == 0.0) return 34'd0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 896;
        if (e >= 255) return {1'b1, 1'b0, d[63], 8'hFF, 23'd0};
        if (e <= 0)   return {1'b0, 1'b1, d[63], 31'd0};
        return {2'b00, d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        int          cls;
        cls = int'($urandom_range(0, 7));
        case (cls)
            0:       e = 8'd0;
            1:       e = 8'(253 + $urandom_range(0, 1));
            2:       e = 8'(1 + $urandom_range(0, 1));
            default: e = 8'(100 + $urandom_range(0, 54));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    assign bus0.in_valid  = in_valid[0];
    assign bus0.in_data   = in_data[0];
    assign bus0.in_sub    = in_sub[0];
    assign bus0.out_ready = out_ready[0];
    assign bus1.in_valid  = in_valid[1];
    assign bus1.in_data   = in_data[1];
    assign bus1.in_sub    = in_sub[1];
    assign bus1.out_ready = out_ready[1];
    assign {bus0.add_ovf, bus0.add_unf, bus0.add_result} = fadd(bus0.add_a, bus0.add_b);
    assign {bus1.add_ovf, bus1.add_unf, bus1.add_result} = fadd(bus1.add_a, bus1.add_b);

    assign o_in_ready[0]  = bus0.in_ready;   assign o_in_ready[1]  = bus1.in_ready;
    assign o_add_a[0]     = bus0.add_a;      assign o_add_a[1]     = bus1.add_a;
    assign o_add_b[0]     = bus0.add_b;      assign o_add_b[1]     = bus1.add_b;
    assign o_add_bit[0]   = bus0.add_bit;    assign o_add_bit[1]   = bus1.add_bit;
    assign o_out_valid[0] = bus0.out_valid;  assign o_out_valid[1] = bus1.out_valid;
    assign o_out_data[0]  = bus0.out_data;   assign o_out_data[1]  = bus1.out_data;
    assign o_out_ovf[0]   = bus0.out_ovf;    assign o_out_ovf[1]   = bus1.out_ovf;
    assign o_out_unf[0]   = bus0.out_unf;    assign o_out_unf[1]   = bus1.out_unf;
    assign o_op_count[1]  = {14'd0, op_count1};

    fp_add_operand_sequencer #(.SETTLE_CYCLES(1), .CNT_W(16)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(bus0.slave), .clr_sticky_i(clr[0]),
        .sticky_ovf_o(o_sticky_ovf[0]), .sticky_unf_o(o_sticky_unf[0]), .op_count_o(o_op_count[0])
    );

    fp_add_operand_sequencer #(.SETTLE_CYCLES(4), .CNT_W(2)) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus1.slave), .clr_sticky_i(clr[1]),
        .sticky_ovf_o(o_sticky_ovf[1]), .sticky_unf_o(o_sticky_unf[1]), .op_count_o(op_count1)
    );

    function automatic logic [15:0] exp_count(input int k);
        return (k == 1) ? 16'(m_cnt[1] % 4) : 16'(m_cnt[0] % 65536);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_sovf[k] = 1'b0; m_sunf[k] = 1'b0;
        end
    endtask

    // Full A/B/result/delivery transaction on instance k, starting and ending at a falling edge.
    task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input int gap, input int stall, input logic do_clr);
        int          s;
        int          lat;
        logic [31:0] eb;
        logic        ebit;
        logic [33:0] r;
        s    = (k == 1) ? 4 : 1;
        eb   = {b[31] ^ sub, b[30:0]};
        ebit = (a[30:23] != 8'd0) && (b[30:23] != 8'd0);
        r    = fadd(a, eb);

        checks++;
        if (o_in_ready[k] !== 1'b1) begin
            errors++; $display("FAIL in_ready_idle k=%0d got %b exp 1", k, o_in_ready[k]);
        end
        in_valid[k] = 1'b1; in_data[k] = a; in_sub[k] = 1'($urandom);
        @(negedge clk);
        in_valid[k] = 1'b0; in_data[k] = $urandom;
        repeat (gap) @(negedge clk);
        checks++;
        if (o_add_a[k] !== a || o_in_ready[k] !== 1'b1 || o_out_valid[k] !== 1'b0) begin
            errors++; $display("FAIL capture_a k=%0d got a=%h rdy=%b ov=%b exp a=%h rdy=1 ov=0",
                               k, o_add_a[k], o_in_ready[k], o_out_valid[k], a);
        end
        in_valid[k] = 1'b1; in_data[k] = b; in_sub[k] = sub;
        @(negedge clk);
        in_valid[k] = 1'b0; in_data[k] = $urandom;
        checks++;
        if (o_add_b[k] !== eb || o_add_bit[k] !== ebit) begin
            errors++; $display("FAIL capture_b k=%0d got b=%h bit=%b exp b=%h bit=%b",
                               k, o_add_b[k], o_add_bit[k], eb, ebit);
        end
        lat = 0;
        while (o_out_valid[k] !== 1'b1 && lat < 20) begin
            checks++;
            if (o_in_ready[k] !== 1'b0) begin
                errors++; $display("FAIL settle_ready k=%0d got %b exp 0", k, o_in_ready[k]);
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != s) begin
            errors++; $display("FAIL latency k=%0d got %0d exp %0d", k, lat, s);
        end
        checks++;
        if (o_out_data[k] !== r[31:0] || o_out_ovf[k] !== r[33] || o_out_unf[k] !== r[32]) begin
            errors++; $display("FAIL result k=%0d got %h o=%b u=%b exp %h o=%b u=%b",
                               k, o_out_data[k], o_out_ovf[k], o_out_unf[k], r[31:0], r[33], r[32]);
        end
        for (int i = 0; i < stall; i++) begin
            in_valid[k] = 1'b1; in_data[k] = $urandom;
            @(negedge clk);
            checks++;
            if (o_out_valid[k] !== 1'b1 || o_out_data[k] !== r[31:0] || o_in_ready[k] !== 1'b0 ||
                o_add_a[k] !== a || o_add_b[k] !== eb) begin
                errors++; $display("FAIL backpressure k=%0d got ov=%b d=%h rdy=%b exp ov=1 d=%h rdy=0",
                                   k, o_out_valid[k], o_out_data[k], o_in_ready[k], r[31:0]);
            end
        end
        in_valid[k] = 1'b0; out_ready[k] = 1'b1; clr[k] = do_clr;
        m_cnt[k]++;
        m_sovf[k] = do_clr ? 1'b0 : (m_sovf[k] | r[33]);
        m_sunf[k] = do_clr ? 1'b0 : (m_sunf[k] | r[32]);
        @(negedge clk);
        out_ready[k] = 1'b0; clr[k] = 1'b0;
        checks++;
        if (o_out_valid[k] !== 1'b0 || o_in_ready[k] !== 1'b1 || o_op_count[k] !== exp_count(k) ||
            o_sticky_ovf[k] !== m_sovf[k] || o_sticky_unf[k] !== m_sunf[k]) begin
            errors++; $display("FAIL delivery k=%0d got ov=%b rdy=%b cnt=%0d so=%b su=%b exp ov=0 rdy=1 cnt=%0d so=%b su=%b",
                               k, o_out_valid[k], o_in_ready[k], o_op_count[k], o_sticky_ovf[k],
                               o_sticky_unf[k], exp_count(k), m_sovf[k], m_sunf[k]);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_add_a[k] !== 32'd0 || o_add_b[k] !== 32'd0 || o_add_bit[k] !== 1'b0 ||
                o_out_valid[k] !== 1'b0 || o_out_data[k] !== 32'd0 || o_out_ovf[k] !== 1'b0 ||
                o_out_unf[k] !== 1'b0 || o_sticky_ovf[k] !== 1'b0 || o_sticky_unf[k] !== 1'b0 ||
                o_op_count[k] !== 16'd0) begin
                errors++; $display("FAIL %s k=%0d got a=%h b=%h bit=%b ov=%b d=%h so=%b su=%b cnt=%0d exp all 0",
                                   tag, k, o_add_a[k], o_add_b[k], o_add_bit[k], o_out_valid[k],
                                   o_out_data[k], o_sticky_ovf[k], o_sticky_unf[k], o_op_count[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_data[k] = 32'd0; in_sub[k] = 1'b0; out_ready[k] = 1'b0; clr[k] = 1'b0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset_values");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_release");
    endtask

    task automatic test_basic();
        do_op(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 0, 0, 1'b0);
        checks++;
        if (o_out_data[0] !== 32'h4000_0000 || o_op_count[0] !== 16'd1) begin
            errors++; $display("FAIL basic_add got %h cnt=%0d exp 40000000 cnt=1", o_out_data[0], o_op_count[0]);
        end
    endtask

    task automatic test_subtract();
        do_op(0, 32'h4040_0000, 32'h3F80_0000, 1'b1, 1, 0, 1'b0);
        checks++;
        if (o_add_b[0] !== 32'hBF80_0000 || o_out_data[0] !== 32'h4000_0000 || o_out_ovf[0] !== 1'b0) begin
            errors++; $display("FAIL subtract got b=%h d=%h o=%b exp b=bf800000 d=40000000 o=0",
                               o_add_b[0], o_out_data[0], o_out_ovf[0]);
        end
    endtask

    task automatic test_back_pressure();
        do_op(0, rand_fp(), rand_fp(), 1'($urandom), 0, 5, 1'b0);
        do_op(0, rand_fp(), rand_fp(), 1'($urandom), 3, 0, 1'b0);
    endtask

    task automatic test_zero_exp_and_overflow();
        do_op(0, 32'h0000_0000, 32'h3F80_0000, 1'b0, 0, 0, 1'b0);
        do_op(0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 0, 1, 1'b0);
        checks++;
        if (o_sticky_ovf[0] !== 1'b1) begin
            errors++; $display("FAIL sticky_set got %b exp 1", o_sticky_ovf[0]);
        end
        do_op(0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 0, 0, 1'b1);
        checks++;
        if (o_sticky_ovf[0] !== 1'b0) begin
            errors++; $display("FAIL sticky_clear_wins got %b exp 0", o_sticky_ovf[0]);
        end
    endtask

    task automatic test_reset_mid_op();
        do_op(1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 0, 0, 1'b0);
        in_valid[1] = 1'b1; in_data[1] = 32'h4040_0000;
        @(negedge clk);
        in_data[1] = 32'h3F80_0000;
        @(negedge clk);
        in_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all_zero("reset_mid_settle");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (o_in_ready[1] !== 1'b1 || o_out_valid[1] !== 1'b0 || o_op_count[1] !== 16'd0) begin
                errors++; $display("FAIL post_reset_idle cyc=%0d got rdy=%b ov=%b cnt=%0d exp rdy=1 ov=0 cnt=0",
                                   i, o_in_ready[1], o_out_valid[1], o_op_count[1]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_settle4_and_wrap();
        for (int i = 0; i < 4; i++)
            do_op(1, rand_fp(), rand_fp(), 1'($urandom), 0, int'($urandom_range(0, 1)), 1'b0);
        checks++;
        if (o_op_count[1] !== 16'd0) begin
            errors++; $display("FAIL count_wrap got %0d exp 0", o_op_count[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            do_op(int'($urandom_range(0, 1)), rand_fp(), rand_fp(), 1'($urandom),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_subtract();
        test_back_pressure();
        test_zero_exp_and_overflow();
        test_reset_mid_op();
        test_settle4_and_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
